// File: rtl/serial_sub_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package serial_sub_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor computing (a - b - bin) mod 2^WIDTH, DIGIT bits per cycle.
// Define SERIAL_SUB_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied low.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last result
// RUN   | shifting one digit per cycle through the subtractor chain
// DONE  | one-cycle done pulse, result final
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             brw;
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dig;
  logic [WIDTH-1:0] dig_ext;
  logic             accept, step, last;

  assign chain[0] = brw;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    full_subtractor u_fs (
      .a    (sa[i]),
      .b    (sb[i]),
      .bin  (chain[i]),
      .diff (dig[i]),
      .bout (chain[i+1])
    );
  end

  // Result digits enter at the MSB end so the LSB digit lands at bit 0 after N shifts.
  always_comb begin
    dig_ext = '0;
    dig_ext[WIDTH-1 -: DIGIT] = dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      sd  <= '0;
      brw <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sd  <= '0;
      brw <= bin;
      cnt <= '0;
    end else if (step) begin
      sa  <= sa >> DIGIT;
      sb  <= sb >> DIGIT;
      sd  <= (sd >> DIGIT) | dig_ext;
      brw <= chain[DIGIT];
      cnt <= cnt + CW'(1);
    end
  end

  assign diff = sd;
  assign bout = brw;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  // Overflow is judged on the final digit only: borrow into the MSB vs borrow out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ovf_r <= 1'b0;
    else if (accept)        ovf_r <= 1'b0;
    else if (step && last)  ovf_r <= chain[DIGIT-1] ^ chain[DIGIT];
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at (8,1), (8,4) and (16,2) against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int sel         = 0;

  logic       s8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8, ov8;
  logic [7:0] d8;

  logic       s4 = 1'b0, bi4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bo4, ov4;
  logic [7:0] d4;

  logic        s16 = 1'b0, bi16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bo16, ov16;
  logic [15:0] d16;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(d8), .bout(bo8), .ovf(ov8));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .bin(bi4),
    .busy(busy4), .done(done4), .diff(d4), .bout(bo4), .ovf(ov4));

  serial_subtractor #(.WIDTH(16), .DIGIT(2)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .bin(bi16),
    .busy(busy16), .done(done16), .diff(d16), .bout(bo16), .ovf(ov16));

  logic        c_busy, c_done, c_bout, c_ovf;
  logic [63:0] c_diff;

  always_comb begin
    c_busy = busy8; c_done = done8; c_diff = 64'(d8); c_bout = bo8; c_ovf = ov8;
    case (sel)
      1: begin c_busy = busy4;  c_done = done4;  c_diff = 64'(d4);  c_bout = bo4;  c_ovf = ov4;  end
      2: begin c_busy = busy16; c_done = done16; c_diff = 64'(d16); c_bout = bo16; c_ovf = ov16; end
      default: ;
    endcase
  end

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic bi, output logic [63:0] d, output logic bo,
                                output logic ov);
    longint ua, ub, sa, sb, r, half, full;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    d  = 64'(ua - ub - longint'(bi)) & 64'(full - 1);
    bo = (ua < ub + longint'(bi));
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    r  = sa - sb - longint'(bi);
    ov = (r < -half) || (r >= half);
`ifndef SERIAL_SUB_OVF_EN
    ov = 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        output int lat, output int bcnt, output int dcnt,
                        output logic [63:0] d, output logic bo, output logic ov);
    @(negedge clk);
    case (sel)
      1: begin a4 = a[7:0];   b4 = b[7:0];   bi4 = bi;  s4 = 1'b1;  end
      2: begin a16 = a[15:0]; b16 = b[15:0]; bi16 = bi; s16 = 1'b1; end
      default: begin a8 = a[7:0]; b8 = b[7:0]; bi8 = bi; s8 = 1'b1; end
    endcase
    @(posedge clk); #1;
    s8 = 1'b0; s4 = 1'b0; s16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a4 = 8'($urandom); b4 = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); bi8 = 1'($urandom);
    lat  = -1;
    bcnt = c_busy ? 1 : 0;
    dcnt = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (c_busy) bcnt++;
      if (c_done) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
      if (!c_busy) break;
    end
    d  = c_diff;
    bo = c_bout;
    ov = c_ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({busy8, done8, d8, bo8, ov8} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_w8 got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               busy8, done8, d8, bo8, ov8);
    end
    vectors++;
    if ({busy4, done4, d4, bo4, ov4, busy16, done16, d16, bo16, ov16} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_others got d4=%h d16=%h busy4=%b busy16=%b want all 0",
               d4, d16, busy4, busy16);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0]  ta[6] = '{8'h05, 8'h00, 8'h10, 8'h80, 8'hFF, 8'h7F};
    logic [7:0]  tb_[6] = '{8'h03, 8'h01, 8'h0F, 8'h01, 8'hFF, 8'hFF};
    logic        tbi[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  td[6] = '{8'h02, 8'hFF, 8'h00, 8'h7F, 8'hFF, 8'h80};
    logic        tbo[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        tov[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] d;
    logic        bo, ov, eov;
    int          lat, bc, dc;
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      eov = tov[i];
`ifndef SERIAL_SUB_OVF_EN
      eov = 1'b0;
`endif
      run_op(64'(ta[i]), 64'(tb_[i]), tbi[i], lat, bc, dc, d, bo, ov);
      vectors++;
      if (d !== 64'(td[i]) || bo !== tbo[i] || ov !== eov) begin
        miscompares++;
        $display("FAIL directed[%0d] got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 i, d[7:0], bo, ov, td[i], tbo[i], eov);
      end
      vectors++;
      if (lat !== 8 || bc !== 9 || dc !== 1) begin
        miscompares++;
        $display("FAIL directed_timing[%0d] got done_edge=%0d busy_cycles=%0d done_cycles=%0d want 8 9 1",
                 i, lat, bc, dc);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (c_diff !== 64'(td[i]) || c_bout !== tbo[i] || c_ovf !== eov || c_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_hold[%0d] got diff=%h bout=%b ovf=%b busy=%b want diff=%h bout=%b ovf=%b busy=0",
                 i, c_diff[7:0], c_bout, c_ovf, c_busy, td[i], tbo[i], eov);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [63:0] ed;
    logic        eb, eo;
    int          lat, dcnt;
    sel = 0;
    model(8, 64'h5C, 64'h21, 1'b1, ed, eb, eo);
    @(negedge clk);
    a8 = 8'h5C; b8 = 8'h21; bi8 = 1'b1; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bi8 = 1'b0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    lat = -1; dcnt = 0;
    for (int k = 5; k <= 24; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
    end
    vectors++;
    if (d8 !== ed[7:0] || bo8 !== eb || ov8 !== eo) begin
      miscompares++;
      $display("FAIL ignore_start got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               d8, bo8, ov8, ed[7:0], eb, eo);
    end
    vectors++;
    if (lat !== 8 || dcnt !== 1) begin
      miscompares++;
      $display("FAIL ignore_start_timing got done_edge=%0d done_count=%0d want 8 1", lat, dcnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ed;
    logic        eb, eo;
    int          dq[$];
    sel = 0;
    model(8, 64'h9B, 64'h37, 1'b0, ed, eb, eo);
    @(negedge clk);
    a8 = 8'h9B; b8 = 8'h37; bi8 = 1'b0; s8 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        dq.push_back(k);
        vectors++;
        if (d8 !== ed[7:0] || bo8 !== eb || ov8 !== eo) begin
          miscompares++;
          $display("FAIL back_to_back_result edge=%0d got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                   k, d8, bo8, ov8, ed[7:0], eb, eo);
        end
      end
    end
    @(negedge clk);
    s8 = 1'b0;
    repeat (12) @(posedge clk);
    vectors++;
    if (dq.size() !== 4) begin
      miscompares++;
      $display("FAIL back_to_back_count got %0d done pulses want 4", dq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (dq[i] !== 9 + 10 * i) begin
          miscompares++;
          $display("FAIL back_to_back_period pulse %0d got edge %0d want %0d", i, dq[i], 9 + 10 * i);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] d;
    logic        bo, ov;
    int          lat, bc, dc, stray;
    sel = 0;
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h18; bi8 = 1'b1; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy8, done8, d8, bo8, ov8} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_abort got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               busy8, done8, d8, bo8, ov8);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL reset_abort_quiet got %0d busy/done cycles want 0", stray);
    end
    run_op(64'h33, 64'h11, 1'b0, lat, bc, dc, d, bo, ov);
    vectors++;
    if (d !== 64'h22 || bo !== 1'b0 || ov !== 1'b0 || lat !== 8) begin
      miscompares++;
      $display("FAIL reset_restart got diff=%h bout=%b ovf=%b done_edge=%0d want diff=22 bout=0 ovf=0 done_edge=8",
               d[7:0], bo, ov, lat);
    end
  endtask

  task automatic test_random(input int s, input int w, input int n, input int count);
    logic [63:0] mask, a, b, ed, d;
    logic        bi, eb, eo, bo, ov;
    int          lat, bc, dc;
    sel  = s;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < count; i++) begin
      a  = {$urandom, $urandom} & mask;
      b  = {$urandom, $urandom} & mask;
      bi = 1'($urandom);
      if (i == 0) begin a = mask; b = '0; bi = 1'b0; end
      if (i == 1) begin a = '0; b = mask; bi = 1'b1; end
      if (s == 1 && i == 2) begin a = 64'hA5; b = 64'h5A; bi = 1'b0; end
      model(w, a, b, bi, ed, eb, eo);
      run_op(a, b, bi, lat, bc, dc, d, bo, ov);
      vectors++;
      if (d !== ed || bo !== eb || ov !== eo) begin
        miscompares++;
        $display("FAIL random_w%0d a=%h b=%h bin=%b got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 w, a, b, bi, d, bo, ov, ed, eb, eo);
      end
      vectors++;
      if (lat !== n || bc !== n + 1 || dc !== 1) begin
        miscompares++;
        $display("FAIL random_timing_w%0d got done_edge=%0d busy_cycles=%0d done_cycles=%0d want %0d %0d 1",
                 w, lat, bc, dc, n, n + 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random(0, 8, 8, 60);
    test_random(1, 8, 2, 30);
    test_random(2, 16, 8, 200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  minuend; captured on accepted start.
REQ-007 b  input  WIDTH  subtrahend; captured on accepted start.
REQ-008 bin  input  1  borrow-in; captured on accepted start.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
REQ-012 bout  output  1  borrow-out, high when a < b + bin (unsigned).
REQ-013 ovf  output  1  two's-complement overflow flag (see Configuration).

Function
REQ-014 FSM states IDLE, RUN, DONE; the block SHALL have no other reachable state.
REQ-015 IDLE with start=1 at edge E0: capture a, b, bin into shift registers; clear digit counter; go to RUN.
REQ-016 RUN: each edge SHALL process the DIGIT LSBs through DIGIT chained full_subtractor instances, shift operands right by DIGIT, insert result digit at diff MSB end, register the borrow.
REQ-017 RUN SHALL last exactly N = WIDTH/DIGIT cycles; at edge EN, go to DONE with diff, bout, ovf final.
REQ-018 done SHALL be high for exactly the one cycle spent in DONE (between EN and EN+1); DONE goes to IDLE unconditionally.
REQ-019 diff, bout, ovf SHALL hold their final values from EN until the next accepted start; intermediate values during RUN are not guaranteed.
REQ-020 start while busy=1 (RUN or DONE) SHALL be ignored; no queuing.
REQ-021 Throughput: one operation per N+2 cycles when start is held high continuously.
REQ-022 Borrow chain: borrow into digit 0 = captured bin; borrow out of final bit = bout.
REQ-023 Operand inputs changing after E0 SHALL not affect the in-flight result.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0, shift registers=0.
REQ-025 rst asserted during RUN or DONE SHALL abort the operation with no done pulse; first accepted start after release begins a fresh operation.

Configuration
REQ-026 Macro SERIAL_SUB_OVF_EN defined: ovf = borrow into MSB XOR borrow out of MSB, valid from EN, held per REQ-019.
REQ-027 Macro SERIAL_SUB_OVF_EN undefined: ovf port remains, tied constant 0; no overflow logic synthesised.

Structure
REQ-028 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and default WIDTH/DIGIT constants.
REQ-029 Sub-module full_subtractor (inputs a, b, bin; outputs diff, bout; purely combinational) SHALL be instantiated DIGIT times via generate.
REQ-030 Counter width SHALL be clog2(N+1) bits.

Verification
REQ-031 WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0, done pulse exactly 8 edges after capture edge, busy high 9 cycles.
REQ-032 WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-033 WIDTH=8, SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; without macro ovf=0.
REQ-034 start pulsed again mid-RUN with new operands -> ignored, original result delivered; start held high -> operations complete every 10 cycles.
REQ-035 rst asserted at RUN cycle 4 -> all outputs 0, no done; a=0x33, b=0x11 afterwards -> diff=0x22.
REQ-036 WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, bin=0 -> diff=0x4B, bout=0, done 2 edges after capture; WIDTH=16, DIGIT=2 exhaustive random compare against a - b - bin.
